// File: rtl/afe_pattern_gen.sv
// rtl/afe_pattern_gen.sv - multi-channel AFE test-pattern source with line/frame framing (optional MODE 3 LFSR under PATTERN_LFSR_EN)
module afe_pattern_gen #(
    parameter int DATA_W   = 14,
    parameter int CHANNELS = 2,
    parameter int H_ACTIVE = 1024,
    parameter int H_BLANK  = 64,
    parameter int HSYNC_W  = 8,
    parameter int V_ACTIVE = 768,
    parameter int V_BLANK  = 4
) (
    input  logic                         i_clk_60m,
    input  logic                         i_nrst,
    input  logic                         i_en,
    input  logic [1:0]                   i_mode,
    input  logic [DATA_W-1:0]            i_const_val,
    output logic [CHANNELS*DATA_W-1:0]   o_pix_data,
    output logic                         o_pix_valid,
    output logic                         o_hsync,
    output logic                         o_vsync,
    output logic [15:0]                  o_frame_cnt,
    output logic                         o_busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HBLANK = 2'd2,
        S_VBLANK = 2'd3
    } state_t;

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);

    // hcnt runs across the whole line (active + blank); vcnt runs across the
    // whole frame, so vertical blank lines are V_ACTIVE..V_TOTAL-1.
    localparam logic [HC_W-1:0] H_ACT_LAST  = HC_W'(H_ACTIVE - 1);
    localparam logic [HC_W-1:0] H_SYNC_LAST = HC_W'(H_ACTIVE + HSYNC_W - 1);
    localparam logic [HC_W-1:0] H_LAST      = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT_LAST  = VC_W'(V_ACTIVE - 1);
    localparam logic [VC_W-1:0] V_LAST      = VC_W'(V_TOTAL - 1);

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [HC_W-1:0]              r_hcnt;
    logic [VC_W-1:0]              r_vcnt;
    logic [1:0]                   r_mode;
    logic [DATA_W-1:0]            r_const;
    logic [15:0]                  r_frame_cnt;

    logic [CHANNELS*DATA_W-1:0]   r_pix_data;
    logic                         r_pix_valid;
    logic                         r_hsync;
    logic                         r_vsync;

    logic [CHANNELS*DATA_W-1:0]   w_pix_data;
    logic                         w_pix_valid;
    logic                         w_hsync;
    logic                         w_vsync;

    logic                         w_line_end;
    logic                         w_frame_end;
    logic                         w_frame_start;

    assign w_line_end    = (r_hcnt == H_LAST);
    assign w_frame_end   = (r_state == S_VBLANK) && w_line_end && (r_vcnt == V_LAST);
    assign w_frame_start = i_en && ((r_state == S_IDLE) || w_frame_end);

`ifdef PATTERN_LFSR_EN
    logic [15:0] r_lfsr;

    // LFSR x^16+x^14+x^13+x^11+1: reseeded per frame, stepped on every active pixel.
    always_ff @(posedge i_clk_60m or negedge i_nrst) begin
        if (!i_nrst) begin
            r_lfsr <= 16'h0001;
        end else if (w_frame_start) begin
            r_lfsr <= 16'h0001;
        end else if (r_state == S_ACTIVE) begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end
`endif

    // State register plus raster counters, frame counter and per-frame config latch.
    always_ff @(posedge i_clk_60m or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state     <= S_IDLE;
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_mode      <= 2'd0;
            r_const     <= '0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_frame_start) begin
                r_hcnt  <= '0;
                r_vcnt  <= '0;
                r_mode  <= i_mode;
                r_const <= i_const_val;
            end else if (r_state != S_IDLE) begin
                if (w_line_end) begin
                    r_hcnt <= '0;
                    r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + VC_W'(1);
                end else begin
                    r_hcnt <= r_hcnt + HC_W'(1);
                end
            end
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    // Next-state logic; EN only matters in IDLE and on the last VBLANK clock.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_en) w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (r_hcnt == H_ACT_LAST) w_state_nxt = S_HBLANK;
            end
            S_HBLANK: begin
                if (w_line_end) w_state_nxt = (r_vcnt == V_ACT_LAST) ? S_VBLANK : S_ACTIVE;
            end
            S_VBLANK: begin
                if (w_frame_end) w_state_nxt = i_en ? S_ACTIVE : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: framing strobes and per-lane pattern for the current raster position.
    always_comb begin
        w_pix_valid = (r_state == S_ACTIVE);
        w_hsync     = (r_state == S_HBLANK) && (r_hcnt <= H_SYNC_LAST);
        w_vsync     = (r_state == S_VBLANK);
        w_pix_data  = '0;
        if (w_pix_valid) begin
            for (int c = 0; c < CHANNELS; c++) begin
                case (r_mode)
                    2'd1: begin
                        w_pix_data[c*DATA_W +: DATA_W] =
                            (|((32'(r_hcnt) ^ 32'(r_vcnt)) & 32'd8)) ? {DATA_W{1'b1}} : '0;
                    end
                    2'd2: begin
                        w_pix_data[c*DATA_W +: DATA_W] = r_const;
                    end
`ifdef PATTERN_LFSR_EN
                    2'd3: begin
                        w_pix_data[c*DATA_W +: DATA_W] =
                            DATA_W'((r_lfsr << (4*c)) | (r_lfsr >> (16 - 4*c)));
                    end
`endif
                    default: begin
                        w_pix_data[c*DATA_W +: DATA_W] =
                            DATA_W'(32'(r_hcnt) * CHANNELS + c + 32'(r_vcnt));
                    end
                endcase
            end
        end
    end

    // Output registers: each value appears one clock after the raster position it describes.
    always_ff @(posedge i_clk_60m or negedge i_nrst) begin
        if (!i_nrst) begin
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
            r_hsync     <= 1'b0;
            r_vsync     <= 1'b0;
        end else begin
            r_pix_data  <= w_pix_data;
            r_pix_valid <= w_pix_valid;
            r_hsync     <= w_hsync;
            r_vsync     <= w_vsync;
        end
    end

    assign o_pix_data  = r_pix_data;
    assign o_pix_valid = r_pix_valid;
    assign o_hsync     = r_hsync;
    assign o_vsync     = r_vsync;
    assign o_frame_cnt = r_frame_cnt;
    assign o_busy      = (r_state != S_IDLE);

endmodule
